param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo.sv | 159 +++++++++++++++
 tb/tb_param_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : param_fifo
//  Brief    : Single-clock parameterised FIFO. It has wrap-bit pointers, a
//             runtime almost-full threshold, a synchronous flush and sticky
//             overflow/underflow flags.
//  Build    : PARAM_FIFO_FWFT_EN -- when defined, data_out shows the head
//             word combinationally (show-ahead). When undefined (default),
//             data_out is a register that loads on each accepted read.
//  Revision : 1.0  initial release
// ============================================================================
module param_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W:0]   thresh,
  input  logic              err_clr,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] C_PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // Storage and pointer state. Each pointer carries one extra wrap bit, so
  // the pointers are equal when the FIFO is empty and differ by DEPTH when
  // it is full.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_rptr;
  logic              r_overflow;
  logic              r_underflow;

  logic [ADDR_W:0]   w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_we;
  logic              w_re;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;

  // Occupancy and status flags come straight from the registered pointers.
  // Modular subtraction gives the correct count across pointer wrap.
  always_comb begin
    w_count = r_wptr - r_rptr;
    w_full  = (w_count == C_DEPTH);
    w_empty = (w_count == '0);
  end

  assign count       = w_count;
  assign full        = w_full;
  assign empty       = w_empty;
  // thresh = 0 keeps this flag high, and thresh > DEPTH keeps it low.
  assign almost_full = (w_count >= thresh);
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

  assign w_waddr = r_wptr[ADDR_W-1:0];
  assign w_raddr = r_rptr[ADDR_W-1:0];

  // Transfer acceptance. A write into a full FIFO is allowed when a read
  // pops in the same cycle. A flush overrides both transfers, so nothing
  // moves (not even the memory) in a flush cycle.
  always_comb begin
    w_we = wr & (~w_full | rd) & ~clr;
    w_re = rd & ~w_empty & ~clr;
  end

  // Error set conditions. A read from empty is flagged even when a write in
  // the same cycle is accepted.
  always_comb begin
    w_ovf_set = wr & w_full & ~rd;
    w_unf_set = rd & w_empty;
  end

  // Pointer update: reset and flush return both pointers to zero, so the
  // next accepted write lands at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_we) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_re) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
    end
  end

  // Sticky error flags. A new set event beats err_clr in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  // Memory write port. It has no reset, so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= data_in;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  // Show-ahead: the head word is visible whenever the FIFO is not empty.
  assign data_out = r_mem[w_raddr];
`else
  logic [DATA_W-1:0] r_data_out;

  // Registered read data: loads on an accepted pop and holds otherwise.
  // A flush does not disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (w_re) begin
      r_data_out <= r_mem[w_raddr];
    end
  end

  assign data_out = r_data_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_param_fifo
//  Brief    : Directed scoreboard bench for param_fifo in the default
//             (registered read data) build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef struct {
    int         due;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr;
  logic       rd;
  logic       err_clr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [5:0] thresh;
  logic [5:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       overflow;
  logic       underflow;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;

  logic [7:0] model_q[$];
  exp_t       exp_q[$];
  exp_t       mon_e;
  bit         m_ovf   = 1'b0;
  bit         m_unf   = 1'b0;
  logic [7:0] last_rd = 8'h00;

  param_fifo #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wr         (wr),
    .data_in    (data_in),
    .rd         (rd),
    .data_out   (data_out),
    .thresh     (thresh),
    .err_clr    (err_clr),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  // Cycle counter: read data becomes due one edge after the read is issued.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare registered read data against queued expectations.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (data_out !== mon_e.d) begin
        errors++;
        $display("FAIL rd_data cyc=%0d actual=%0h required=%0h", cyc, data_out, mon_e.d);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Check the status outputs against the reference model.
  task automatic chk_status();
    chk("count", 32'(count), 32'(model_q.size()));
    chk("empty", 32'(empty), 32'(model_q.size() == 0));
    chk("full", 32'(full), 32'(model_q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(model_q.size() >= int'(thresh)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // Issue one cycle of stimulus (starts and ends at posedge+1), update the
  // model, and queue any expected read data.
  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit c = 1'b0, input bit ec = 1'b0);
    bit   m_full;
    bit   m_empty;
    exp_t e;
    wr      = w;
    data_in = d;
    rd      = r;
    clr     = c;
    err_clr = ec;
    m_full  = (model_q.size() == DEPTH);
    m_empty = (model_q.size() == 0);
    if (c) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && m_full && !r) m_ovf = 1'b1;
      else if (ec)           m_ovf = 1'b0;
      if (r && m_empty)      m_unf = 1'b1;
      else if (ec)           m_unf = 1'b0;
      if (r && !m_empty) begin
        e.due   = cyc + 1;
        e.d     = model_q.pop_front();
        last_rd = e.d;
        exp_q.push_back(e);
      end
      if (w && (!m_full || r)) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
    wr      = 1'b0;
    rd      = 1'b0;
    clr     = 1'b0;
    err_clr = 1'b0;
    chk_status();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    clr     = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    err_clr = 1'b0;
    data_in = 8'h00;
    thresh  = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_af_thresh0", 32'(almost_full), 1);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_data_out", 32'(data_out), 0);
    thresh = 6'd8;
    #1;
    chk("rst_af_thresh8", 32'(almost_full), 0);
    @(posedge clk);
    #1;

    // Fill 0x00..0x1F, then probe threshold boundaries
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 32);
    thresh = 6'd33;
    #1;
    chk("af_thresh33", 32'(almost_full), 0);
    thresh = 6'd32;
    #1;
    chk("af_thresh32", 32'(almost_full), 1);
    thresh = 6'd8;

    // Drain: data must come back 0x00..0x1F in order
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_last", 32'(data_out), 32'h1F);

    // Refill, then overflow with err_clr interplay
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 32);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_beats_errclr", 32'(overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_errclr", 32'(overflow), 0);

    // Full boundary: simultaneous write and read while full
    step(1'b1, 8'hAA, 1'b1);
    chk("fullbd_count", 32'(count), 32);
    chk("fullbd_ovf", 32'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    chk("fullbd_last", 32'(data_out), 32'hAA);
    chk("fullbd_empty", 32'(empty), 1);

    // Empty boundary: simultaneous write and read while empty
    step(1'b1, 8'h55, 1'b1);
    chk("emptybd_unf", 32'(underflow), 1);
    chk("emptybd_count", 32'(count), 1);
    chk("emptybd_hold", 32'(data_out), 32'hAA);
    step(1'b0, 8'h00, 1'b1);
    chk("emptybd_read", 32'(data_out), 32'h55);

    // Wrap: occupancy toggles 7/8 around thresh=8 for 100 pairs
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b0);
      chk("wrap_af_hi", 32'(almost_full), 1);
      step(1'b0, 8'h00, 1'b1);
      chk("wrap_af_lo", 32'(almost_full), 0);
    end
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);

    // Flush with count=5; clr beats wr/rd and leaves data_out alone
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("clr_setup_count", 32'(count), 5);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    chk("clr_count", 32'(count), 0);
    chk("clr_unf", 32'(underflow), 0);
    chk("clr_data_hold", 32'(data_out), 32'(last_rd));
    step(1'b1, 8'h3C, 1'b0);
    chk("clr_addr0", 32'(dut.r_mem[0]), 32'h3C);
    step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-cycle with count=5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hD0 + i), 1'b0);
    chk("arst_setup_count", 32'(count), 5);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_count", 32'(count), 0);
    chk("arst_full", 32'(full), 0);
    chk("arst_data_out", 32'(data_out), 0);
    model_q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    last_rd = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 8'h77, 1'b0);
    chk("arst_addr0", 32'(dut.r_mem[0]), 32'h77);
    step(1'b0, 8'h00, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_left", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
